// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// All outputs are registered; each serial bit lasts CLKS_PER_BIT clocks.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       parity_bit,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  // done is registered, so it is raised one count before the final clock of the stop bit
  localparam logic [CntW-1:0] CntDone = CntW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic            par_q;
  logic            par_en_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (data_valid) begin
            shreg_q  <= data_in;
            par_q    <= parity_bit;
            par_en_q <= (parity_type == 2'b01) || (parity_type == 2'b10);
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= StStart;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StData;
            tx_out  <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              if (par_en_q) begin
                state_q <= StParity;
                tx_out  <= par_q;
              end else begin
                state_q <= StStop;
                tx_out  <= 1'b1;
              end
            end else begin
              tx_out <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StStop;
            tx_out  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntDone) done <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_out  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table vectors, random frames against a bit-list model,
// back-to-back frames and a mid-frame reset.
module tb_uart_tx_frame;

  localparam int unsigned C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       parity_bit = 1'b0;
  logic       tx_out;
  logic       busy;
  logic       done;

  int n_pass = 0;
  int n_total = 0;

  uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .parity_type(parity_type),
    .parity_bit (parity_bit),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  pt;
    logic        pb;
    logic [10:0] line;  // serial bit k of the frame at index k
    int          nbits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: list the frame's serial bits in time order from the framing rules.
  task automatic model(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                       output logic [10:0] line, output int nbits);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pt == 2'b01 || pt == 2'b10) q.push_back(pb);
    q.push_back(1'b1);
    line = '0;
    nbits = q.size();
    for (int i = 0; i < nbits; i++) line[i] = q[i];
  endtask

  // Entered and left at a negedge.
  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("%s_tx[%0d]", tag, i), tx_out, 1);
      chk($sformatf("%s_busy[%0d]", tag, i), busy, 0);
      chk($sformatf("%s_done[%0d]", tag, i), done, 0);
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] pt,
                           input logic pb, input logic [10:0] line, input int nbits,
                           input bit disturb);
    int last;
    data_in = d;
    parity_type = pt;
    parity_bit = pb;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    last = nbits * C - 1;
    for (int k = 0; k <= last; k++) begin
      chk($sformatf("%s_tx[%0d]", tag, k), tx_out, line[k / C]);
      chk($sformatf("%s_busy[%0d]", tag, k), busy, 1);
      chk($sformatf("%s_done[%0d]", tag, k), done, (k == last) ? 1 : 0);
      if (disturb) begin
        data_in = 8'($urandom);
        parity_type = 2'($urandom);
        parity_bit = 1'($urandom);
        data_valid = (k == 13) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
    end
    expect_idle({tag, "_after"}, 2);
  endtask

  vec_t        vecs[5];
  logic [10:0] line, line2;
  int          nbits, nbits2;
  logic [7:0]  rd;
  logic [1:0]  rpt;
  logic        rpb;

  initial begin
    vecs[0] = '{d: 8'hA5, pt: 2'b10, pb: 1'b0, line: 11'b10101001010, nbits: 11};
    vecs[1] = '{d: 8'h00, pt: 2'b01, pb: 1'b1, line: 11'b11000000000, nbits: 11};
    vecs[2] = '{d: 8'hFF, pt: 2'b00, pb: 1'b1, line: 11'b01111111110, nbits: 10};
    vecs[3] = '{d: 8'hFF, pt: 2'b11, pb: 1'b0, line: 11'b01111111110, nbits: 10};
    vecs[4] = '{d: 8'h5A, pt: 2'b01, pb: 1'b1, line: 11'b11010110100, nbits: 11};

    // Reset state and idle with no stimulus
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    expect_idle("idle", 20);

    // Table vectors; the second one also gets mid-frame input noise and a stray data_valid
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pt, vecs[i].pb, vecs[i].line,
                vecs[i].nbits, i == 1);
    end

    // Random frames against the model
    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rpt = 2'($urandom_range(0, 3));
      rpb = (rpt == 2'b01) ? ~^rd : (rpt == 2'b10) ? ^rd : 1'($urandom);
      model(rd, rpt, rpb, line, nbits);
      run_frame($sformatf("rnd%0d", i), rd, rpt, rpb, line, nbits, 1'($urandom));
    end

    // Back-to-back: data_valid held high across two frames, one idle cycle between
    model(8'h3C, 2'b00, 1'b0, line, nbits);
    model(8'hC3, 2'b10, 1'b0, line2, nbits2);
    data_in = 8'h3C;
    parity_type = 2'b00;
    parity_bit = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < (nbits + nbits2) * C + 1; k++) begin
      if (k < nbits * C) begin
        chk($sformatf("b2b_tx[%0d]", k), tx_out, line[k / C]);
        chk($sformatf("b2b_busy[%0d]", k), busy, 1);
        chk($sformatf("b2b_done[%0d]", k), done, (k == nbits * C - 1) ? 1 : 0);
      end else if (k == nbits * C) begin
        chk("b2b_gap_tx", tx_out, 1);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_done", done, 0);
      end else begin
        chk($sformatf("b2b_tx[%0d]", k), tx_out, line2[(k - nbits * C - 1) / C]);
        chk($sformatf("b2b_busy[%0d]", k), busy, 1);
        chk($sformatf("b2b_done[%0d]", k), done, (k == (nbits + nbits2) * C) ? 1 : 0);
      end
      if (k == 0) begin
        data_in = 8'hC3;
        parity_type = 2'b10;
        parity_bit = 1'b0;
      end
      if (k == nbits * C + 1) data_valid = 1'b0;
      @(negedge clk);
    end
    expect_idle("b2b_after", 3);

    // Reset during data bit 3, then a clean frame
    data_in = 8'hF0;
    parity_type = 2'b10;
    parity_bit = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4 * C + 1) @(negedge clk);
    chk("midrst_pre_tx", tx_out, 0);
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    expect_idle("midrst_hold", 2);
    rst = 1'b1;
    expect_idle("midrst_rel", 12 * C);
    model(8'hF0, 2'b10, 1'b0, line, nbits);
    run_frame("midrst_new", 8'hF0, 2'b10, 1'b0, line, nbits, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
